// File: rtl/router_pkt_tx_if.sv
// Handshake bundle between the packet source, its host and the router input.
// PARITY_INJ_EN adds the inj_parity_err request sideband.
interface router_pkt_tx_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_dest;
    logic [5:0]  req_len;
    logic        pl_valid;
    logic        pl_ready;
    logic [7:0]  pl_data;
    logic        busy;
    logic        pkt_valid;
    logic [7:0]  data_out;
    logic        tx_done;
    logic        req_err;
    logic [15:0] pkt_cnt;
`ifdef PARITY_INJ_EN
    logic        inj_parity_err;
`endif

    modport master (
`ifdef PARITY_INJ_EN
        input  inj_parity_err,
`endif
        input  req_valid, req_dest, req_len,
        input  pl_valid, pl_data, busy,
        output req_ready, pl_ready, pkt_valid,
        output data_out, tx_done, req_err, pkt_cnt
    );

    modport slave (
`ifdef PARITY_INJ_EN
        output inj_parity_err,
`endif
        output req_valid, req_dest, req_len,
        output pl_valid, pl_data, busy,
        input  req_ready, pl_ready, pkt_valid,
        input  data_out, tx_done, req_err, pkt_cnt
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Router packet source: buffers a payload, then sends header/payload/parity.
// Optional PARITY_INJ_EN: inj_parity_err inverts the transmitted parity byte.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 2,
    parameter int MAX_LEN    = 63
) (
    input logic             clock,
    input logic             resetn,
    router_pkt_tx_if.master bus
);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, HDR, PAY, PAR, GAP
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      dest_q, dest_d;
    logic [5:0]      len_q, len_d;
    logic [5:0]      idx_q, idx_d;
    logic [7:0]      par_q, par_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [7:0]      data_q, data_d;
    logic            pv_q, pv_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            wr_en;
    logic [7:0]      par_out;
    logic [7:0]      buf_q [MAX_LEN];

`ifdef PARITY_INJ_EN
    logic inj_q, inj_d;
    assign par_out = par_q ^ {8{inj_q}};
`else
    assign par_out = par_q;
`endif

    assign bus.req_ready = (state_q == IDLE);
    assign bus.pl_ready  = (state_q == LOAD);
    assign bus.pkt_valid = pv_q;
    assign bus.data_out  = data_q;
    assign bus.tx_done   = done_q;
    assign bus.req_err   = err_q;
    assign bus.pkt_cnt   = cnt_q;

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        len_d   = len_q;
        idx_d   = idx_q;
        par_d   = par_q;
        gap_d   = gap_q;
        data_d  = data_q;
        pv_d    = pv_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
`ifdef PARITY_INJ_EN
        inj_d   = inj_q;
`endif
        unique case (state_q)
            IDLE: if (bus.req_valid) begin
                if (bus.req_dest == 2'd3 || bus.req_len == 6'd0 ||
                    int'(bus.req_len) > MAX_LEN) begin
                    err_d = 1'b1;
                end else begin
                    dest_d  = bus.req_dest;
                    len_d   = bus.req_len;
                    par_d   = {bus.req_len, bus.req_dest};
                    idx_d   = 6'd0;
                    state_d = LOAD;
`ifdef PARITY_INJ_EN
                    inj_d   = bus.inj_parity_err;
`endif
                end
            end
            LOAD: if (bus.pl_valid) begin
                wr_en = 1'b1;
                par_d = par_q ^ bus.pl_data;
                // Header goes out on the same edge as the last payload write
                if (idx_q == len_q - 6'd1) begin
                    state_d = HDR;
                    data_d  = {len_q, dest_q};
                    pv_d    = 1'b1;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            HDR: if (!bus.busy) begin
                state_d = PAY;
                data_d  = buf_q[0];
                idx_d   = 6'd0;
            end
            PAY: if (!bus.busy) begin
                if (idx_q == len_q - 6'd1) begin
                    state_d = PAR;
                    data_d  = par_out;
                    pv_d    = 1'b0;
                end else begin
                    idx_d  = idx_q + 6'd1;
                    data_d = buf_q[idx_q + 6'd1];
                end
            end
            PAR: if (!bus.busy) begin
                done_d  = 1'b1;
                cnt_d   = cnt_q + 16'd1;
                data_d  = 8'h00;
                gap_d   = '0;
                state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
                else gap_d = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            dest_q  <= 2'd0;
            len_q   <= 6'd0;
            idx_q   <= 6'd0;
            par_q   <= 8'h00;
            gap_q   <= '0;
            data_q  <= 8'h00;
            pv_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
`ifdef PARITY_INJ_EN
            inj_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            pv_q    <= pv_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef PARITY_INJ_EN
            inj_q   <= inj_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) buf_q[idx_q] <= bus.pl_data;
    end
endmodule
